alu_sequencer: RTL and testbench

- Drives the 8-bit ALU's control/operand side and consumes its outputs.
- Accepts an operation request (control code plus operands) from the decode/execute stage through a valid/ready handshake.
- Presents the request to the ALU for one cycle, then captures the result and the carry/overflow/compare outputs.
- Maintains the architectural flag register (C, V, Z, N, CMP) and feeds the stored carry back into the next op, so multi-byte add/sub chains work.

---
 rtl/alu_sequencer.sv | 105 ++++++++++
 tb/tb_alu_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences one op at a time through the 8-bit ALU and keeps the flag register
module alu_sequencer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_cins,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic          req_use_c,
  input  logic          req_set_flags,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic [4:0]    flags,
  input  logic          flag_clr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [7:0]    alu_cins,
  output logic          alu_oe,
  output logic          alu_carryin,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carryout,
  input  logic          alu_overout,
  input  logic          alu_cmpo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  logic   set_flags_q;
  logic   c_at_drive;

  // Carry as it will stand once the accepting edge has also applied any flag clear.
  assign c_at_drive = flag_clr ? 1'b0 : flags[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      flags       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cins    <= '0;
      alu_oe      <= 1'b0;
      alu_carryin <= 1'b0;
      set_flags_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flag_clr) begin
            flags <= '0;
          end
          if (req_valid && req_ready) begin
            alu_a       <= req_a;
            alu_b       <= req_b;
            alu_cins    <= req_cins;
            alu_carryin <= req_use_c & c_at_drive;
            set_flags_q <= req_set_flags;
            alu_oe      <= 1'b1;
            req_ready   <= 1'b0;
            state       <= DRIVE;
          end
        end
        DRIVE: begin
          resp_data <= alu_out;
          // A capturing op beats a simultaneous clear.
          if (set_flags_q) begin
            flags <= {alu_cmpo, alu_out[DW-1], (alu_out == '0), alu_overout, alu_carryout};
          end else if (flag_clr) begin
            flags <= '0;
          end
          alu_oe     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (flag_clr) begin
            flags <= '0;
          end
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          alu_oe     <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized and directed bench for alu_sequencer with an ALU stub
module tb_alu_sequencer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_cins;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          req_use_c;
  logic          req_set_flags;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [4:0]    flags;
  logic          flag_clr;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [7:0]    alu_cins;
  logic          alu_oe;
  logic          alu_carryin;
  logic [DW-1:0] alu_out;
  logic          alu_carryout;
  logic          alu_overout;
  logic          alu_cmpo;

  logic [DW-1:0] stub_out = '0;
  logic          stub_co = 1'b0;
  logic          stub_ov = 1'b0;
  logic          stub_cmp = 1'b0;

  // Stub outputs are inverted whenever the ALU is not enabled, so mistimed capture shows up.
  assign alu_out      = alu_oe ? stub_out : ~stub_out;
  assign alu_carryout = alu_oe ? stub_co  : ~stub_co;
  assign alu_overout  = alu_oe ? stub_ov  : ~stub_ov;
  assign alu_cmpo     = alu_oe ? stub_cmp : ~stub_cmp;

  always #5 clk = ~clk;

  alu_sequencer #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cins(req_cins),
    .req_a(req_a), .req_b(req_b), .req_use_c(req_use_c), .req_set_flags(req_set_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .flags(flags), .flag_clr(flag_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cins(alu_cins), .alu_oe(alu_oe),
    .alu_carryin(alu_carryin), .alu_out(alu_out), .alu_carryout(alu_carryout),
    .alu_overout(alu_overout), .alu_cmpo(alu_cmpo)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: where the op is (0 waiting, 1 on the ALU, 2 holding result) and what it must show.
  int         m_phase = 0;
  logic [7:0] m_a = '0, m_b = '0, m_cins = '0, m_data = '0;
  logic       m_cin = 1'b0, m_sf = 1'b0;
  logic [4:0] m_f = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_a = '0; m_b = '0; m_cins = '0; m_data = '0;
      m_cin = 1'b0; m_sf = 1'b0; m_f = '0;
    end else if (m_phase == 0) begin
      if (flag_clr) m_f = '0;
      if (req_valid) begin
        m_a = req_a; m_b = req_b; m_cins = req_cins; m_sf = req_set_flags;
        m_cin = req_use_c && m_f[0];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_data = stub_out;
      if (m_sf) m_f = {stub_cmp, stub_out[7], stub_out == 8'h00, stub_ov, stub_co};
      else if (flag_clr) m_f = '0;
      m_phase = 2;
    end else begin
      if (flag_clr) m_f = '0;
      if (resp_ready) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(m_phase == 0));
    check("alu_oe", 32'(alu_oe), 32'(m_phase == 1));
    check("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
    check("resp_data", 32'(resp_data), 32'(m_data));
    check("flags", 32'(flags), 32'(m_f));
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(m_b));
    check("alu_cins", 32'(alu_cins), 32'(m_cins));
    check("alu_carryin", 32'(alu_carryin), 32'(m_cin));
  end

  logic drv_oe, drv_cin, drv_rv;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic uc, input logic sf,
                       input logic [7:0] so, input logic sco, input logic sov, input logic scmp,
                       input logic clr_in_drive);
    req_valid = 1'b1; req_cins = 8'($urandom); req_a = a; req_b = b;
    req_use_c = uc; req_set_flags = sf; resp_ready = 1'b0;
    stub_out = so; stub_co = sco; stub_ov = sov; stub_cmp = scmp;
    step();
    req_valid = 1'b0; req_a = 8'($urandom); req_b = 8'($urandom);
    req_use_c = ~uc; req_set_flags = ~sf; flag_clr = clr_in_drive;
    drv_oe = alu_oe; drv_cin = alu_carryin; drv_rv = resp_valid;
    step();
    flag_clr = 1'b0;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    int oe_cnt, rv_cnt;
    rst_n = 1'b0; req_valid = 1'b0; req_cins = '0; req_a = '0; req_b = '0;
    req_use_c = 1'b0; req_set_flags = 1'b0; resp_ready = 1'b0; flag_clr = 1'b0;
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_flags", 32'(flags), 32'h0);
    rst_n = 1'b1;
    step();

    issue(8'h12, 8'h48, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    check("single_oe_in_drive", 32'(drv_oe), 32'h1);
    check("single_no_early_resp", 32'(drv_rv), 32'h0);
    check("single_resp_valid_t2", 32'(resp_valid), 32'h1);
    check("single_resp_data", 32'(resp_data), 32'h5A);
    check("single_flags", 32'(flags), 32'b10000);
    release_resp();

    issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("chain1_flags", 32'(flags), 32'b00101);
    release_resp();
    issue(8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    check("chain2_carryin", 32'(drv_cin), 32'h1);
    check("chain2_flags", 32'(flags), 32'b00001);
    release_resp();
    issue(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    check("chain3_carryin", 32'(drv_cin), 32'h0);
    check("chain3_flags", 32'(flags), 32'b00000);
    release_resp();

    issue(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    check("neg_ovf_flags", 32'(flags), 32'b01010);
    release_resp();
    issue(8'h30, 8'h03, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
    check("noflags_flags", 32'(flags), 32'b01010);
    check("noflags_data", 32'(resp_data), 32'h33);
    release_resp();
    issue(8'h00, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clr_vs_capture", 32'(flags), 32'b10001);
    release_resp();

    issue(8'hC0, 8'h04, 1'b0, 1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1; req_set_flags = 1'b0; req_a = 8'h99;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_resp_valid", 32'(resp_valid), 32'h1);
      check("bp_resp_data", 32'(resp_data), 32'hC4);
      check("bp_flags", 32'(flags), 32'b01000);
      check("bp_req_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_back_to_idle", 32'(req_ready), 32'h1);
    check("bp_not_yet_accepted", 32'(alu_oe), 32'h0);
    step();
    check("bp_accept_after", 32'(alu_oe), 32'h1);
    req_valid = 1'b0;
    step();
    release_resp();

    req_valid = 1'b1; req_set_flags = 1'b1; req_use_c = 1'b0;
    step();
    req_valid = 1'b0;
    check("rst_pre_oe", 32'(alu_oe), 32'h1);
    check("rst_pre_flags", 32'(flags), 32'b01000);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(alu_oe), 32'h0);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_mid_flags", 32'(flags), 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_stray_resp", 32'(resp_valid), 32'h0);
      check("rst_req_ready_after", 32'(req_ready), 32'h1);
    end

    issue(8'h80, 8'h7F, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("resp_clr_before", 32'(flags), 32'b01001);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("resp_clr_after", 32'(flags), 32'h0);
    check("resp_clr_still_valid", 32'(resp_valid), 32'h1);
    release_resp();

    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_cins = 8'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
      req_use_c = 1'($urandom); req_set_flags = ($urandom_range(0, 3) != 0);
      resp_ready = 1'($urandom); flag_clr = ($urandom_range(0, 7) == 0);
      stub_out = 8'($urandom); stub_co = 1'($urandom);
      stub_ov = 1'($urandom); stub_cmp = 1'($urandom);
      step();
    end

    req_valid = 1'b0; flag_clr = 1'b0; resp_ready = 1'b1;
    step(); step(); step();
    oe_cnt = 0; rv_cnt = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req_a = 8'($urandom); req_b = 8'($urandom); req_cins = 8'($urandom);
      req_use_c = 1'($urandom); req_set_flags = 1'($urandom);
      stub_out = 8'($urandom); stub_co = 1'($urandom);
      stub_ov = 1'($urandom); stub_cmp = 1'($urandom);
      step();
      if (alu_oe) oe_cnt++;
      if (resp_valid) rv_cnt++;
    end
    req_valid = 1'b0;
    check("b2b_oe_pulses", 32'(oe_cnt), 32'd10);
    check("b2b_responses", 32'(rv_cnt), 32'd10);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
